// File: rtl/niveles_carga_pkg.sv
// Shared types and constant helpers for the filtered battery charge-level classifier.
package niveles_carga_pkg;

    typedef enum logic [1:0] {
        CRITICO   = 2'd0,
        REGULAR   = 2'd1,
        ACEPTABLE = 2'd2,
        OPTIMO    = 2'd3
    } nivel_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Level boundary k of a full-scale value, integer division.
    function automatic int unsigned umbral(input int unsigned k, input int unsigned max_v);
        return (k * max_v) / 4;
    endfunction

    function automatic int unsigned resta_sat(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 0;
    endfunction

    // Bit 0 = critico ... bit 3 = optimo.
    function automatic logic [3:0] un_caliente(input nivel_e n);
        return 4'b0001 << n;
    endfunction

endpackage

// File: rtl/ventana_promedio.sv
// Sums the packed battery readings per strobe and keeps a moving-average window.
module ventana_promedio
    import niveles_carga_pkg::*;
#(
    parameter  int unsigned NUM_BAT  = 2,
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned LOG_VENT = 2,
    localparam int unsigned SUM_W    = WIDTH + clog2(NUM_BAT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_BAT*WIDTH-1:0] carga_i,
    input  logic                     muestra_i,
    output logic [SUM_W-1:0]         promedio_o,
    output logic                     lleno_o,
    output logic                     valido_o
);

    localparam int unsigned VENT  = 32'd1 << LOG_VENT;
    localparam int unsigned ACC_W = SUM_W + LOG_VENT;
    localparam int unsigned CNT_W = LOG_VENT + 1;

    logic [SUM_W-1:0] suma_c;
    logic [SUM_W-1:0] ventana_q [VENT];
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] llenado_q;
    logic [CNT_W-1:0] llenado_d;
    logic [SUM_W-1:0] promedio_q;
    logic             lleno_q;
    logic             valido_q;

    always_comb begin : sumador
        suma_c = '0;
        for (int unsigned i = 0; i < NUM_BAT; i++) begin
            suma_c = suma_c + SUM_W'(carga_i[i*WIDTH +: WIDTH]);
        end
    end

    assign acc_d     = acc_q + ACC_W'(suma_c) - ACC_W'(ventana_q[VENT-1]);
    assign llenado_d = (llenado_q == CNT_W'(VENT)) ? llenado_q : llenado_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin : etapa1
        if (!rst_n) begin
            for (int unsigned i = 0; i < VENT; i++) begin
                ventana_q[i] <= '0;
            end
            acc_q      <= '0;
            llenado_q  <= '0;
            promedio_q <= '0;
            lleno_q    <= 1'b0;
            valido_q   <= 1'b0;
        end else begin
            valido_q <= muestra_i;
            if (muestra_i) begin
                ventana_q[0] <= suma_c;
                for (int unsigned i = VENT - 1; i > 0; i--) begin
                    ventana_q[i] <= ventana_q[i-1];
                end
                acc_q      <= acc_d;
                promedio_q <= SUM_W'(acc_d >> LOG_VENT);
                llenado_q  <= llenado_d;
                lleno_q    <= (llenado_d == CNT_W'(VENT));
            end
        end
    end

    assign promedio_o = promedio_q;
    assign lleno_o    = lleno_q;
    assign valido_o   = valido_q;

endmodule

// File: rtl/niveles_carga_filtrado.sv
// Classifies the windowed total charge into four levels with hysteresis and N-sample confirmation.
module niveles_carga_filtrado
    import niveles_carga_pkg::*;
#(
    parameter  int unsigned NUM_BAT  = 2,
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned LOG_VENT = 2,
    parameter  int unsigned HIST     = 1,
    parameter  int unsigned CONFIRM  = 2,
    localparam int unsigned SUM_W    = WIDTH + clog2(NUM_BAT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_BAT*WIDTH-1:0] carga_baterias,
    input  logic                     muestra_valida,
    output logic [SUM_W-1:0]         promedio,
    output logic                     nivel_valido,
    output logic                     optimo,
    output logic                     aceptable,
    output logic                     regular,
    output logic                     critico,
    output logic                     alarma_critico
);

    localparam int unsigned MAX   = NUM_BAT * ((32'd1 << WIDTH) - 1);
    localparam int unsigned T1    = umbral(1, MAX);
    localparam int unsigned T2    = umbral(2, MAX);
    localparam int unsigned T3    = umbral(3, MAX);
    localparam int unsigned SUB1  = T1 + HIST;
    localparam int unsigned SUB2  = T2 + HIST;
    localparam int unsigned SUB3  = T3 + HIST;
    localparam int unsigned BAJ1  = resta_sat(T1, HIST);
    localparam int unsigned BAJ2  = resta_sat(T2, HIST);
    localparam int unsigned BAJ3  = resta_sat(T3, HIST);
    localparam int unsigned CNT_W = clog2(CONFIRM + 1);

    logic [SUM_W-1:0] promedio_w;
    logic             lleno_w;
    logic             valido_w;

    ventana_promedio #(
        .NUM_BAT  (NUM_BAT),
        .WIDTH    (WIDTH),
        .LOG_VENT (LOG_VENT)
    ) u_ventana (
        .clk        (clk),
        .rst_n      (rst_n),
        .carga_i    (carga_baterias),
        .muestra_i  (muestra_valida),
        .promedio_o (promedio_w),
        .lleno_o    (lleno_w),
        .valido_o   (valido_w)
    );

    nivel_e           estado_q;
    logic             cargado_q;
    logic             dir_q;
    logic [CNT_W-1:0] cuenta_q;
    logic [3:0]       niveles_q;
    logic             alarma_q;

    logic [31:0]      p_c;
    nivel_e           crudo_c;
    nivel_e           destino_c;
    logic             sube_c;
    logic             baja_c;
    logic [CNT_W-1:0] cuenta_sig_c;

    assign p_c = 32'(promedio_w);

    // Raw level, up/down requests for the current state and the candidate confirm count.
    always_comb begin : clasifica
        crudo_c      = CRITICO;
        sube_c       = 1'b0;
        baja_c       = 1'b0;
        if (p_c >= T3) begin
            crudo_c = OPTIMO;
        end else if (p_c >= T2) begin
            crudo_c = ACEPTABLE;
        end else if (p_c >= T1) begin
            crudo_c = REGULAR;
        end
        case (estado_q)
            CRITICO: begin
                sube_c = (p_c >= SUB1);
            end
            REGULAR: begin
                sube_c = (p_c >= SUB2);
                baja_c = (p_c < BAJ1);
            end
            ACEPTABLE: begin
                sube_c = (p_c >= SUB3);
                baja_c = (p_c < BAJ2);
            end
            OPTIMO: begin
                baja_c = (p_c < BAJ3);
            end
            default: ;
        endcase
        destino_c    = sube_c ? nivel_e'(estado_q + 2'd1) : nivel_e'(estado_q - 2'd1);
        cuenta_sig_c = ((cuenta_q != '0) && (dir_q == sube_c)) ? cuenta_q + CNT_W'(1)
                                                                : CNT_W'(1);
    end

    // Stage 2: evaluates only on the cycle after an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin : fsm_nivel
        if (!rst_n) begin
            estado_q  <= CRITICO;
            cargado_q <= 1'b0;
            dir_q     <= 1'b0;
            cuenta_q  <= '0;
            niveles_q <= '0;
            alarma_q  <= 1'b0;
        end else begin
            alarma_q <= 1'b0;
            if (valido_w && lleno_w) begin
                if (!cargado_q) begin
                    cargado_q <= 1'b1;
                    estado_q  <= crudo_c;
                    cuenta_q  <= '0;
                    niveles_q <= un_caliente(crudo_c);
                    alarma_q  <= (crudo_c == CRITICO);
                end else if (sube_c || baja_c) begin
                    dir_q <= sube_c;
                    if (cuenta_sig_c >= CNT_W'(CONFIRM)) begin
                        estado_q  <= destino_c;
                        cuenta_q  <= '0;
                        niveles_q <= un_caliente(destino_c);
                        alarma_q  <= (destino_c == CRITICO);
                    end else begin
                        cuenta_q <= cuenta_sig_c;
                    end
                end else begin
                    cuenta_q <= '0;
                end
            end
        end
    end

    assign promedio       = promedio_w;
    assign nivel_valido   = cargado_q;
    assign critico        = niveles_q[0];
    assign regular        = niveles_q[1];
    assign aceptable      = niveles_q[2];
    assign optimo         = niveles_q[3];
    assign alarma_critico = alarma_q;

endmodule

// File: tb/tb_niveles_carga_filtrado.sv
// Directed bench for niveles_carga_filtrado: default, wide (4x8) and single-sample-window instances.
module tb_niveles_carga_filtrado;

    localparam logic [3:0] NIN = 4'b0000;
    localparam logic [3:0] CRI = 4'b0001;
    localparam logic [3:0] REG = 4'b0010;
    localparam logic [3:0] ACE = 4'b0100;
    localparam logic [3:0] OPT = 4'b1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0]  carga_a = '0;
    logic        val_a   = 1'b0;
    logic [4:0]  prom_a;
    logic        nv_a, op_a, ac_a, re_a, cr_a, al_a;
    logic [3:0]  niv_a;

    logic [31:0] carga_b = '0;
    logic        val_b   = 1'b0;
    logic [9:0]  prom_b;
    logic        nv_b, op_b, ac_b, re_b, cr_b, al_b;
    logic [3:0]  niv_b;

    logic [7:0]  carga_c = '0;
    logic        val_c   = 1'b0;
    logic [4:0]  prom_c;
    logic        nv_c, op_c, ac_c, re_c, cr_c, al_c;
    logic [3:0]  niv_c;

    int unsigned checks  = 0;
    int unsigned errores = 0;
    int unsigned pulsos  = 0;
    int unsigned pulsos_ini;

    int unsigned fill_p [3] = '{7, 15, 22};
    int unsigned sub_p  [5] = '{10, 12, 14, 16, 16};
    logic [3:0]  sub_n  [5] = '{REG, REG, REG, REG, ACE};
    int unsigned baj_p  [5] = '{22, 15, 7, 0, 0};
    logic [3:0]  baj_n  [5] = '{OPT, OPT, ACE, ACE, REG};

    assign niv_a = {op_a, ac_a, re_a, cr_a};
    assign niv_b = {op_b, ac_b, re_b, cr_b};
    assign niv_c = {op_c, ac_c, re_c, cr_c};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (al_a) pulsos <= pulsos + 1;
    end

    niveles_carga_filtrado u_dut (
        .clk(clk), .rst_n(rst_n), .carga_baterias(carga_a), .muestra_valida(val_a),
        .promedio(prom_a), .nivel_valido(nv_a), .optimo(op_a), .aceptable(ac_a),
        .regular(re_a), .critico(cr_a), .alarma_critico(al_a)
    );

    niveles_carga_filtrado #(.NUM_BAT(4), .WIDTH(8)) u_big (
        .clk(clk), .rst_n(rst_n), .carga_baterias(carga_b), .muestra_valida(val_b),
        .promedio(prom_b), .nivel_valido(nv_b), .optimo(op_b), .aceptable(ac_b),
        .regular(re_b), .critico(cr_b), .alarma_critico(al_b)
    );

    niveles_carga_filtrado #(.LOG_VENT(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .carga_baterias(carga_c), .muestra_valida(val_c),
        .promedio(prom_c), .nivel_valido(nv_c), .optimo(op_c), .aceptable(ac_c),
        .regular(re_c), .critico(cr_c), .alarma_critico(al_c)
    );

    task automatic chequear(input string tag, input int unsigned obs, input int unsigned esp);
        checks++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [3:0] b0, input logic [3:0] b1);
        carga_a = {b1, b0};
        val_a   = 1'b1;
        @(posedge clk);
        #1;
        val_a   = 1'b0;
    endtask

    task automatic strobe_c(input logic [3:0] b0, input logic [3:0] b1);
        carga_c = {b1, b0};
        val_c   = 1'b1;
        @(posedge clk);
        #1;
        val_c   = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chequear("rst_prom", prom_a, 0);
        chequear("rst_nv", nv_a, 0);
        chequear("rst_niv", niv_a, NIN);
        chequear("rst_alarma", al_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fill with full charge.
        for (int i = 0; i < 3; i++) begin
            strobe_a(4'd15, 4'd15);
            chequear("fill_prom", prom_a, fill_p[i]);
            chequear("fill_nv", nv_a, 0);
            chequear("fill_niv", niv_a, NIN);
        end
        strobe_a(4'd15, 4'd15);
        chequear("fill_prom4", prom_a, 30);
        chequear("fill_nv_pre", nv_a, 0);
        tick();
        chequear("fill_nv_ok", nv_a, 1);
        chequear("fill_optimo", niv_a, OPT);
        chequear("fill_alarma", al_a, 0);

        reset_pulse();
        for (int i = 0; i < 4; i++) strobe_a(4'd4, 4'd4);
        chequear("carga_prom", prom_a, 8);
        tick();
        chequear("carga_regular", niv_a, REG);

        reset_pulse();
        pulsos_ini = pulsos;
        for (int i = 0; i < 4; i++) strobe_a(4'd1, 4'd2);
        chequear("crit_prom", prom_a, 3);
        chequear("crit_alarma_pre", al_a, 0);
        tick();
        chequear("crit_niv", niv_a, CRI);
        chequear("crit_alarma", al_a, 1);
        tick();
        chequear("crit_alarma_fin", al_a, 0);
        repeat (3) tick();
        chequear("crit_pulsos", pulsos - pulsos_ini, 1);

        // Hysteresis on the way up from regular.
        reset_pulse();
        for (int i = 0; i < 4; i++) strobe_a(4'd4, 4'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            strobe_a(4'd8, 4'd8);
            chequear("sube_prom", prom_a, sub_p[i]);
            tick();
            chequear("sube_niv", niv_a, sub_n[i]);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            chequear("reposo_niv", niv_a, ACE);
        end
        chequear("reposo_prom", prom_a, 16);
        chequear("reposo_nv", nv_a, 1);

        // Confirmed step-down from optimo.
        reset_pulse();
        for (int i = 0; i < 4; i++) strobe_a(4'd15, 4'd15);
        tick();
        chequear("baja_ini", niv_a, OPT);
        for (int i = 0; i < 5; i++) begin
            strobe_a(4'd0, 4'd0);
            chequear("baja_prom", prom_a, baj_p[i]);
            tick();
            chequear("baja_niv", niv_a, baj_n[i]);
        end

        // Async reset in the middle of a pending down confirmation.
        strobe_a(4'd0, 4'd0);
        tick();
        chequear("mid_niv", niv_a, REG);
        #3 rst_n = 1'b0;
        #1;
        chequear("async_prom", prom_a, 0);
        chequear("async_nv", nv_a, 0);
        chequear("async_niv", niv_a, NIN);
        chequear("async_alarma", al_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe_a(4'd15, 4'd15);
            tick();
            chequear("refill_nv", nv_a, 0);
        end
        strobe_a(4'd15, 4'd15);
        tick();
        chequear("refill_nv_ok", nv_a, 1);
        chequear("refill_niv", niv_a, OPT);

        // Four 8-bit batteries at full scale.
        for (int i = 0; i < 4; i++) begin
            carga_b = {4{8'd255}};
            val_b   = 1'b1;
            @(posedge clk);
            #1;
            val_b   = 1'b0;
        end
        chequear("big_prom", prom_b, 1020);
        tick();
        chequear("big_nv", nv_b, 1);
        chequear("big_niv", niv_b, OPT);

        // Single-sample window: alternating requests never confirm.
        strobe_c(4'd4, 4'd4);
        chequear("alt_prom", prom_c, 8);
        tick();
        chequear("alt_carga", niv_c, REG);
        for (int i = 0; i < 4; i++) begin
            strobe_c(4'd8, 4'd8);
            tick();
            chequear("alt_sube", niv_c, REG);
            strobe_c(4'd1, 4'd2);
            tick();
            chequear("alt_baja", niv_c, REG);
        end
        strobe_c(4'd8, 4'd8);
        tick();
        chequear("alt_conf1", niv_c, REG);
        strobe_c(4'd8, 4'd8);
        tick();
        chequear("alt_conf2", niv_c, ACE);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule

// File: doc/niveles_carga_filtrado.md
Name: niveles_carga_filtrado

Overview:
- Parametrised successor to the two-battery charge-level classifier.
- Sums NUM_BAT packed battery readings on each sample strobe and smooths the total with a moving-average window.
- Classifies the average into optimo/aceptable/regular/critico using hysteresis and N-sample confirmation.
- Sits between the battery ADC sampling logic and the status LEDs/alarm logic.

Parameters:
- NUM_BAT, 2: number of batteries (>=1).
- WIDTH, 4: bits per battery reading.
- LOG_VENT, 2: log2 of the moving-average window depth (window = 4 samples).
- HIST, 1: hysteresis margin, in average-sum LSBs.
- CONFIRM, 2: consecutive same-direction requests needed before a level change (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- carga_baterias  in  NUM_BAT*WIDTH  packed readings; battery i at [i*WIDTH +: WIDTH].
- muestra_valida  in  1  sample strobe; readings accepted on a cycle where it is high.
- promedio  out  SUM_W  windowed average of the total charge.
- nivel_valido  out  1  high once the window has filled.
- optimo  out  1  one-hot level output.
- aceptable  out  1  one-hot level output.
- regular  out  1  one-hot level output.
- critico  out  1  one-hot level output.
- alarma_critico  out  1  one-cycle pulse when the level enters critico.

Behaviour:
- Widths:
  - SUM_W = WIDTH + clog2(NUM_BAT).
  - MAX = NUM_BAT*(2^WIDTH-1).
  - Accumulator width is SUM_W + LOG_VENT. No overflow is possible.
- Thresholds: T_k = (k*MAX)/4 with integer division, k = 1, 2, 3.
- Raw level of average p:
  - optimo if p >= T3
  - aceptable if p >= T2
  - regular if p >= T1
  - else critico.
- Reset (asynchronous, immediate): window, accumulator, fill counter, confirm counter and promedio cleared to 0. nivel_valido, all level outputs and alarma_critico are 0.
- Stage 1, the cycle after a strobe:
  - Newest sum is shifted into the window; oldest is dropped.
  - acc <= acc + new - oldest.
  - promedio <= (acc + new - oldest) >> LOG_VENT, truncating.
  - Fill counter increments, saturating at 2^LOG_VENT.
- Stage 2, the following cycle:
  - Level state updates; outputs change 2 cycles after the strobe.
- While the fill counter is below 2^LOG_VENT: nivel_valido = 0 and the level outputs are all 0.
- On the stage-2 cycle in which the window first becomes full: state is loaded directly with the raw level (no hysteresis). nivel_valido = 1.
- FSM states are CRITICO, REGULAR, ACEPTABLE, OPTIMO. Exactly one level output is high while nivel_valido = 1.
- Up request from state L (not OPTIMO): p >= T_{L+1} + HIST.
- Down request from state L (not CRITICO): p < T_L - HIST, with the subtraction saturating at 0.
- Confirm counter:
  - Increments on a request in the same direction as the previous one.
  - Set to 1 on a request in the opposite direction.
  - Cleared on a stage-2 evaluation with no request.
  - On reaching CONFIRM: state moves one level in that direction and the counter clears. Never more than one level per evaluation.
- Stage 2 evaluates only on cycles following an accepted sample. Without strobes, all state holds indefinitely.
- Back-to-back strobes on every cycle are all accepted; the pipeline is fully overlapped.
- alarma_critico pulses for one cycle when:
  - the state transitions into CRITICO, or
  - the initial fill loads CRITICO.
- Reset asserted mid-window or mid-confirmation discards everything. After reset, a full window refill is required again.

Decomposition:
- Package niveles_carga_pkg:
  - level enum with encoding CRITICO=0, REGULAR=1, ACEPTABLE=2, OPTIMO=3
  - clog2 function
  - threshold function umbral(k, MAX).
- Sub-module ventana_promedio (parameters NUM_BAT, WIDTH, LOG_VENT):
  - packed-input adder tree, window shift register, accumulator, fill counter.
  - outputs promedio, lleno and a one-cycle valid.
- The top level holds the hysteresis FSM, confirm counter and output decode.

Test Plan (defaults: MAX=30, T1=7, T2=15, T3=22):
- Fill: reset, then 3 strobes of (15,15) -> nivel_valido=0 and all levels 0. 4th strobe -> promedio=30 one cycle later; optimo=1 and nivel_valido=1 two cycles after the strobe.
- Initial load: fill with (4,4) -> promedio=8 and regular=1 (raw load with no HIST). Fill with (1,2) -> promedio=3, critico=1, alarma_critico pulses exactly once.
- Hysteresis up: steady at average 8 (regular), then strobes of (8,8):
  - averages run 10, 12, 14, 16, 16
  - no change at 15
  - request at the 4th strobe, aceptable=1 two cycles after the 5th.
- Confirmed step-down: steady at 30 (optimo), then strobes of (0,0):
  - averages run 22, 15, 7, 0, 0
  - aceptable after the 3rd strobe
  - regular after the 5th
  - one level per confirmation.
- Hold and direction reset: hold muestra_valida low 50 cycles -> outputs stable. Alternate up/down requests -> confirm counter restarts each time, no level change.
- Async reset: assert rst_n low mid-confirmation, between clock edges -> all outputs 0 immediately. After release, 4 strobes are needed before nivel_valido=1. Also run NUM_BAT=4, WIDTH=8 with all readings 255 -> promedio=1020, optimo.
